// File: rtl/mon_seq_pkg.sv
// Shared types for the monitor counter sequencer: the sequencing FSM states
// and the helper that sizes index/counter registers.
package mon_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SETTLE,
    SCAN,
    CLEAR,
    DONE
  } state_t;

  // Never returns zero so that a register sized from it is always legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mon_seq_period_timer.sv
// Free-running period timer: one-cycle pulse_o once every PERIOD_CYCLES cycles.
module mon_seq_period_timer
  import mon_seq_pkg::*;
#(
  parameter int PERIOD_CYCLES = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic pulse_o
);

  localparam int CW = idx_width(PERIOD_CYCLES);
  localparam logic [CW-1:0] TERM = CW'(PERIOD_CYCLES - 1);

  logic [CW-1:0] count_q;

  // Keeps counting regardless of whether the sequencer accepts the pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (count_q == TERM) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + 1'b1;
    end
  end

  assign pulse_o = (count_q == TERM);

endmodule

// File: rtl/monitor_counter_sequencer.sv
// Freezes a bank of counters, streams each value out over a valid/ready port,
// optionally clears them. Define MON_SEQ_PERIODIC_EN for automatic snapshots.
module monitor_counter_sequencer
  import mon_seq_pkg::*;
#(
  parameter int N_COUNTERS    = 8,
  parameter int BIT_WIDTH     = 16,
  parameter int PERIOD_CYCLES = 1000000
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic                             clear_on_read_i,
  input  logic [N_COUNTERS*BIT_WIDTH-1:0]  counter_values_i,
  output logic                             latch_counter_o,
  output logic                             reset_counter_o,
  output logic [BIT_WIDTH-1:0]             data_o,
  output logic [idx_width(N_COUNTERS)-1:0] index_o,
  output logic                             valid_o,
  input  logic                             ready_i,
  output logic                             busy_o,
  output logic                             done_o
);

  localparam int IW = idx_width(N_COUNTERS);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_COUNTERS - 1);

  state_t               state_q, state_d;
  logic [IW-1:0]        idx_q;
  logic [IW-1:0]        idx_inc;
  logic [BIT_WIDTH-1:0] data_q;
  logic                 clear_flag_q;
  logic                 start_req;
  logic                 xfer;
  logic [BIT_WIDTH-1:0] slices [N_COUNTERS];

  for (genvar k = 0; k < N_COUNTERS; k++) begin : g_slice
    assign slices[k] = counter_values_i[k*BIT_WIDTH +: BIT_WIDTH];
  end

`ifdef MON_SEQ_PERIODIC_EN
  logic timer_pulse;

  mon_seq_period_timer #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_period_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .pulse_o(timer_pulse)
  );

  assign start_req = start_i | timer_pulse;
`else
  logic unused_period;
  assign unused_period = ^PERIOD_CYCLES;
  assign start_req     = start_i;
`endif

  assign xfer    = (state_q == SCAN) && ready_i;
  assign idx_inc = idx_q + 1'b1;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_req) state_d = LATCH;
      LATCH:   state_d = SETTLE;
      SETTLE:  state_d = SCAN;
      SCAN:    if (xfer && (idx_q == LAST_IDX)) state_d = clear_flag_q ? CLEAR : DONE;
      CLEAR:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters are already frozen by the time SETTLE ends, so slice 0 is
  // captured there and each transfer preloads the next slice with no bubble.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      data_q       <= '0;
      clear_flag_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if ((state_q == IDLE) && start_req) begin
        clear_flag_q <= clear_on_read_i;
      end
      if (state_q == SETTLE) begin
        idx_q  <= '0;
        data_q <= slices[0];
      end else if (xfer) begin
        if (idx_q != LAST_IDX) begin
          idx_q  <= idx_inc;
          data_q <= slices[idx_inc];
        end else begin
          idx_q <= '0;
        end
      end
    end
  end

  assign latch_counter_o = (state_q == LATCH) || (state_q == SETTLE) || (state_q == SCAN);
  assign reset_counter_o = (state_q == CLEAR);
  assign valid_o         = (state_q == SCAN);
  assign busy_o          = (state_q != IDLE);
  assign done_o          = (state_q == DONE);
  assign data_o          = data_q;
  assign index_o         = idx_q;

endmodule

// File: tb/tb_monitor_counter_sequencer.sv
// Self-checking bench for monitor_counter_sequencer with four 16-bit counters.
module tb_monitor_counter_sequencer;

  localparam int N  = 4;
  localparam int BW = 16;

  typedef struct packed {
    logic [1:0]  idx;
    logic [15:0] data;
  } xfer_t;

  typedef struct {
    logic [N*BW-1:0] vals;
    logic            clr;
    bit              rdy_random;
    int              start_hold;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            clear_on_read = 1'b0;
  logic [N*BW-1:0] counter_values = '0;
  logic            ready = 1'b0;
  logic            latch_counter;
  logic            reset_counter;
  logic [BW-1:0]   data;
  logic [1:0]      index;
  logic            valid;
  logic            busy;
  logic            done;

  int    vec_count = 0;
  int    miscompares = 0;
  xfer_t exp_q[$];
  vec_t  vectors[5];

  monitor_counter_sequencer #(
    .N_COUNTERS   (N),
    .BIT_WIDTH    (BW),
    .PERIOD_CYCLES(50)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .start_i         (start),
    .clear_on_read_i (clear_on_read),
    .counter_values_i(counter_values),
    .latch_counter_o (latch_counter),
    .reset_counter_o (reset_counter),
    .data_o          (data),
    .index_o         (index),
    .valid_o         (valid),
    .ready_i         (ready),
    .busy_o          (busy),
    .done_o          (done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One full snapshot: a cycle-level model of when latch/busy/done/clear
  // should appear, with the readout checked against the scoreboard.
  task automatic applyStimulus(input vec_t v);
    int    last_xfer   = -1;
    int    done_c      = -1;
    int    clr_c       = -1;
    int    clr_cnt     = 0;
    int    done_cnt    = 0;
    int    first_valid = -1;
    bit    prev_stall  = 0;
    bit    scan_over   = 0;
    logic [15:0] pd = '0;
    logic [1:0]  pi = '0;
    xfer_t e;
    counter_values = v.vals;
    clear_on_read  = v.clr;
    for (int k = 0; k < N; k++) begin
      e.idx  = 2'(k);
      e.data = v.vals[k*BW +: BW];
      exp_q.push_back(e);
    end
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (prev_stall) begin
        checkOutput("stall_valid", valid, 1);
        checkOutput("stall_data", data, pd);
        checkOutput("stall_index", index, pi);
      end
      if (reset_counter) begin clr_cnt++; clr_c = c; end
      if (done) begin done_cnt++; done_c = c; end
      if (valid && first_valid < 0) first_valid = c;
      checkOutput("latch_level", latch_counter, (c >= 1) && !scan_over);
      checkOutput("busy_level", busy, (c >= 1) && !(done_c >= 0 && c > done_c));
      start = (c < v.start_hold);
      ready = v.rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = valid && !ready;
      pd = data;
      pi = index;
      if (valid && ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("extra_transfer", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("xfer_index", index, e.idx);
          checkOutput("xfer_data", data, e.data);
          if (exp_q.size() == 0) begin
            last_xfer = c;
            scan_over = 1;
          end
        end
      end
      if (done_c >= 0 && c >= done_c + 3) break;
    end
    start = 1'b0;
    checkOutput("first_valid_cycle", first_valid, 3);
    checkOutput("transfers_left", exp_q.size(), 0);
    checkOutput("done_pulses", done_cnt, 1);
    checkOutput("clear_pulses", clr_cnt, v.clr);
    checkOutput("done_latency", done_c - last_xfer, v.clr ? 2 : 1);
    if (v.clr) checkOutput("clear_latency", clr_c - last_xfer, 1);
    exp_q.delete();
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_latch"}, latch_counter, 0);
    checkOutput({tag, "_reset_counter"}, reset_counter, 0);
    checkOutput({tag, "_data"}, data, 0);
    checkOutput({tag, "_index"}, index, 0);
    checkOutput({tag, "_valid"}, valid, 0);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_done"}, done, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected end before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit reached;
    vectors[0] = '{{16'd40, 16'd30, 16'd20, 16'd10}, 1'b0, 1'b0, 1};
    vectors[1] = '{{16'd40, 16'd30, 16'd20, 16'd10}, 1'b1, 1'b0, 1};
    vectors[2] = '{{16'h0000, 16'hFFFF, 16'h5A5A, 16'hA5A5}, 1'b0, 1'b1, 1};
    vectors[3] = '{{16'd4, 16'd3, 16'd2, 16'd1}, 1'b0, 1'b0, 3};
    vectors[4] = '{{16'hBEEF, 16'h1234, 16'h8001, 16'h7FFE}, 1'b1, 1'b1, 3};

    #23;
    checkIdleZero("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("idle_busy", busy, 0);

    foreach (vectors[i]) begin
      applyStimulus(vectors[i]);
      repeat (2) @(negedge clk);
    end

    // Abort in the middle of the scan: no clear or done may follow.
    counter_values = {16'd40, 16'd30, 16'd20, 16'd10};
    clear_on_read  = 1'b1;
    start = 1'b1;
    ready = 1'b1;
    reached = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid && index == 2'd2) begin
        reached = 1;
        break;
      end
    end
    checkOutput("abort_reached_index2", reached, 1);
    checkOutput("abort_data_before", data, 16'd30);
    ready = 1'b0;
    #2 rst = 1'b1;
    #1 checkIdleZero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkOutput("post_abort_done", done, 0);
      checkOutput("post_abort_reset_counter", reset_counter, 0);
      checkOutput("post_abort_busy", busy, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end

endmodule
